// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: folds E0/F0/E1 prefixes into key events and queues them in a FWFT FIFO.
// Define KBD_ASCII_EN to add the combinational ASCII translation of the head event on rd_ascii.
module ps2_scancode_decoder #(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 2500000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             code_in,
  input  logic                   code_valid,
  input  logic                   rd_en,
  output logic [15:0]            rd_data,
  output logic [7:0]             rd_ascii,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  input  logic                   clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK,
    S_PAUSE
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_skip;
  logic [2:0]    w_skip_nxt;
  logic [TW-1:0] r_to_cnt;
  logic          w_timeout;
  logic          w_push;
  logic          w_ev_ext;
  logic          w_ev_brk;

  logic          r_lshift;
  logic          r_rshift;
  logic          r_caps;

  logic [11:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_drop;
  logic [11:0]   w_event;
  logic [11:0]   w_head;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_skip   <= 3'd0;
      r_to_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_skip  <= w_skip_nxt;
      if (code_valid || (r_state == S_IDLE) || w_timeout)
        r_to_cnt <= '0;
      else
        r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  // A strobe always takes priority over an expiring timeout in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_skip_nxt  = r_skip;
    w_push      = 1'b0;
    w_ev_ext    = 1'b0;
    w_ev_brk    = 1'b0;
    w_timeout   = (r_state != S_IDLE) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));
    if (code_valid) begin
      case (r_state)
        S_IDLE: begin
          if (code_in == 8'hE0) begin
            w_state_nxt = S_EXT;
          end else if (code_in == 8'hF0) begin
            w_state_nxt = S_BRK;
          end else if (code_in == 8'hE1) begin
            w_state_nxt = S_PAUSE;
            w_skip_nxt  = 3'd7;
          end else if (!(code_in inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF})) begin
            w_push = 1'b1;
          end
        end
        S_EXT: begin
          if (code_in == 8'hF0) begin
            w_state_nxt = S_EXT_BRK;
          end else begin
            w_state_nxt = S_IDLE;
            w_push      = !(code_in inside {8'h12, 8'h59});
            w_ev_ext    = 1'b1;
          end
        end
        S_BRK: begin
          w_state_nxt = S_IDLE;
          w_push      = 1'b1;
          w_ev_brk    = 1'b1;
        end
        S_EXT_BRK: begin
          w_state_nxt = S_IDLE;
          w_push      = !(code_in inside {8'h12, 8'h59});
          w_ev_ext    = 1'b1;
          w_ev_brk    = 1'b1;
        end
        S_PAUSE: begin
          w_skip_nxt = r_skip - 3'd1;
          if (r_skip == 3'd1)
            w_state_nxt = S_IDLE;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  // Event carries the modifier state as it was before this byte.
  assign w_event = {r_caps, r_lshift | r_rshift, w_ev_brk, w_ev_ext, code_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
      r_caps   <= 1'b0;
    end else if (w_push && !w_ev_ext) begin
      if (code_in == 8'h12) r_lshift <= !w_ev_brk;
      if (code_in == 8'h59) r_rshift <= !w_ev_brk;
      if ((code_in == 8'h58) && !w_ev_brk) r_caps <= !r_caps;
    end
  end

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = rd_en && !w_empty;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wptr] <= w_event;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr)
        r_wptr <= r_wptr + AW'(1);
      if (w_pop)
        r_rptr <= r_rptr + AW'(1);
      if (w_wr && !w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop && !w_wr)
        r_count <= r_count - CW'(1);
      if (w_drop)
        r_overflow <= 1'b1;
      else if (clr_ovf)
        r_overflow <= 1'b0;
    end
  end

  assign w_head   = r_mem[r_rptr];
  assign rd_data  = w_empty ? 16'h0000 : {4'h0, w_head};
  assign empty    = w_empty;
  assign full     = w_full;
  assign count    = r_count;
  assign overflow = r_overflow;

`ifdef KBD_ASCII_EN
  function automatic logic [7:0] f_ascii(input logic [11:0] ev);
    logic [7:0] ch;
    ch = 8'h00;
    case (ev[7:0])
      8'h1C: ch = "a";  8'h32: ch = "b";  8'h21: ch = "c";  8'h23: ch = "d";
      8'h24: ch = "e";  8'h2B: ch = "f";  8'h34: ch = "g";  8'h33: ch = "h";
      8'h43: ch = "i";  8'h3B: ch = "j";  8'h42: ch = "k";  8'h4B: ch = "l";
      8'h3A: ch = "m";  8'h31: ch = "n";  8'h44: ch = "o";  8'h4D: ch = "p";
      8'h15: ch = "q";  8'h2D: ch = "r";  8'h1B: ch = "s";  8'h2C: ch = "t";
      8'h3C: ch = "u";  8'h2A: ch = "v";  8'h1D: ch = "w";  8'h22: ch = "x";
      8'h35: ch = "y";  8'h1A: ch = "z";
      8'h45: ch = "0";  8'h16: ch = "1";  8'h1E: ch = "2";  8'h26: ch = "3";
      8'h25: ch = "4";  8'h2E: ch = "5";  8'h36: ch = "6";  8'h3D: ch = "7";
      8'h3E: ch = "8";  8'h46: ch = "9";
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      8'h66: ch = 8'h08;
      8'h76: ch = 8'h1B;
      default: ch = 8'h00;
    endcase
    if ((ch >= 8'h61) && (ch <= 8'h7A) && (ev[10] ^ ev[11]))
      ch = ch - 8'h20;
    if (ev[8] || ev[9])
      ch = 8'h00;
    return ch;
  endfunction

  assign rd_ascii = w_empty ? 8'h00 : f_ascii(w_head);
`else
  assign rd_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: directed scenarios plus randomized byte streams
// compared every cycle against a sequence-level reference model.
module tb_ps2_scancode_decoder;

  localparam int DEPTH = 8;
  localparam int TO    = 16;

  logic        clk;
  logic        rst;
  logic [7:0]  code_in;
  logic        code_valid;
  logic        rd_en;
  logic [15:0] rd_data;
  logic [7:0]  rd_ascii;
  logic        empty;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic        clr_ovf;

  int errors = 0;
  int checks = 0;

  ps2_scancode_decoder #(.DEPTH(DEPTH), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid), .rd_en(rd_en),
    .rd_data(rd_data), .rd_ascii(rd_ascii), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

`ifdef KBD_ASCII_EN
  localparam bit ASC_EN = 1'b1;
`else
  localparam bit ASC_EN = 1'b0;
`endif

  // Letters a..z and digits 0..9 listed by their Set-2 make codes.
  logic [7:0] k_letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] k_digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  function automatic logic [7:0] ascii_of(input logic [11:0] ev);
    if (!ASC_EN || ev[8] || ev[9]) return 8'h00;
    for (int i = 0; i < 26; i++)
      if (k_letters[i] == ev[7:0])
        return (ev[10] ^ ev[11]) ? 8'(8'h41 + i) : 8'(8'h61 + i);
    for (int i = 0; i < 10; i++)
      if (k_digits[i] == ev[7:0]) return 8'(8'h30 + i);
    case (ev[7:0])
      8'h29: return 8'h20;
      8'h5A: return 8'h0D;
      8'h66: return 8'h08;
      8'h76: return 8'h1B;
      default: return 8'h00;
    endcase
  endfunction

  // Reference model: bytes of an unfinished prefix sequence collect in pend.
  logic [11:0] mq[$];
  logic [7:0]  pend[$];
  bit          m_lsh, m_rsh, m_caps, m_ovf, m_ready;
  int unsigned cyc = 0;
  int unsigned last_stb = 0;

  always @(posedge clk) begin
    bit do_pop, have_ev, ext, brk, drop;
    logic [7:0] c;
    do_pop = 0; have_ev = 0; ext = 0; brk = 0; drop = 0;
    c = code_in;
    if (rst) begin
      mq.delete();
      pend.delete();
      m_lsh = 0; m_rsh = 0; m_caps = 0; m_ovf = 0;
      m_ready = 1;
    end else if (m_ready) begin
      do_pop = rd_en && (mq.size() != 0);
      if (code_valid) begin
        if ((pend.size() != 0) && ((cyc - last_stb) > TO)) pend.delete();
        last_stb = cyc;
        pend.push_back(c);
        if (pend[0] == 8'hE1) begin
          if (pend.size() == 8) pend.delete();
        end else if ((pend.size() == 1) && ((c == 8'hE0) || (c == 8'hF0))) begin
        end else if ((pend.size() == 2) && (pend[0] == 8'hE0) && (c == 8'hF0)) begin
        end else begin
          ext = (pend[0] == 8'hE0);
          brk = (pend.size() >= 2) && (pend[pend.size()-2] == 8'hF0);
          have_ev = 1;
          if ((pend.size() == 1) && (c inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF}))
            have_ev = 0;
          if (ext && ((c == 8'h12) || (c == 8'h59))) have_ev = 0;
          pend.delete();
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (have_ev) begin
        if (mq.size() < DEPTH) mq.push_back({m_caps, m_lsh | m_rsh, brk, ext, c});
        else drop = 1;
      end
      if (drop) m_ovf = 1;
      else if (clr_ovf) m_ovf = 0;
      if (have_ev && !ext) begin
        if (c == 8'h12) m_lsh = !brk;
        if (c == 8'h59) m_rsh = !brk;
        if ((c == 8'h58) && !brk) m_caps = !m_caps;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_ready) begin
      logic [15:0] ed;
      logic [7:0]  ea;
      ed = (mq.size() != 0) ? {4'h0, mq[0]} : 16'h0000;
      ea = (mq.size() != 0) ? ascii_of(mq[0]) : 8'h00;
      check("empty", empty, mq.size() == 0);
      check("full", full, mq.size() == DEPTH);
      check("count", count, 32'(mq.size()));
      check("overflow", overflow, m_ovf);
      check("rd_data", rd_data, ed);
      check("rd_ascii", rd_ascii, ea);
    end
  end

  task automatic send(input logic [7:0] b);
    code_in = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic expect_pop(input string nm, input logic [15:0] d);
    check(nm, rd_data, d);
    pop();
  endtask

  logic [7:0] pool [20] = '{8'hE0, 8'hF0, 8'hE1, 8'h12, 8'h59, 8'h58, 8'h1C, 8'h32, 8'h15, 8'h45,
                            8'h16, 8'h29, 8'h5A, 8'h66, 8'h76, 8'hAA, 8'hFA, 8'h00, 8'hFF, 8'h1A};

  initial begin
    int gap;
    int rd_pct;
    rst = 1'b1; code_valid = 1'b0; code_in = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    check("rst_empty", empty, 1);
    check("rst_count", count, 0);
    check("rst_data", rd_data, 0);
    check("rst_ovf", overflow, 0);

    send(8'h1C);
    check("first_empty", empty, 0);
    check("first_data", rd_data, 16'h001C);
    check("first_ascii", rd_ascii, ASC_EN ? 8'h61 : 8'h00);
    pop();
    check("first_popped", empty, 1);

    send(8'h12); send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    check("shift_count", count, 4);
    expect_pop("shift_make", 16'h0012);
    check("shift_ascii", rd_ascii, ASC_EN ? 8'h41 : 8'h00);
    expect_pop("shifted_a", 16'h041C);
    expect_pop("a_break", 16'h061C);
    expect_pop("shift_break", 16'h0612);

    send(8'hE0); send(8'hF0); send(8'h75);
    expect_pop("ext_break", 16'h0375);
    send(8'hE0); send(8'h12);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    send(8'hAA);
    check("no_event_seq", empty, 1);
    send(8'h1C);
    expect_pop("after_pause", 16'h001C);

    send(8'h58); send(8'h1C);
    expect_pop("caps_make", 16'h0058);
    check("caps_ascii", rd_ascii, ASC_EN ? 8'h41 : 8'h00);
    expect_pop("caps_a", 16'h081C);
    send(8'h58); send(8'h1C);
    expect_pop("caps_make2", 16'h0858);
    expect_pop("caps_off_a", 16'h001C);

    for (int i = 0; i <= DEPTH; i++) send(8'(8'h20 + i));
    check("ovf_full", full, 1);
    check("ovf_count", count, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_head", rd_data, 16'h0020);
    code_in = 8'h30; code_valid = 1'b1; rd_en = 1'b1;
    @(negedge clk);
    code_valid = 1'b0; rd_en = 1'b0;
    check("pushpop_count", count, DEPTH);
    check("pushpop_head", rd_data, 16'h0021);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    check("ovf_cleared", overflow, 0);
    repeat (DEPTH) pop();
    check("drained", empty, 1);

    send(8'hE0);
    repeat (TO - 1) @(negedge clk);
    send(8'h1C);
    expect_pop("just_in_time", 16'h011C);
    send(8'hE0);
    repeat (TO) @(negedge clk);
    send(8'h1C);
    expect_pop("timed_out", 16'h001C);

    send(8'hF0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send(8'h1C);
    expect_pop("rst_mid_seq", 16'h001C);

    gap = 0;
    for (int i = 0; i < 3000; i++) begin
      rd_pct  = (i < 1500) ? 15 : 60;
      rd_en   = ($urandom_range(0, 99) < rd_pct);
      clr_ovf = ($urandom_range(0, 99) < 3);
      rst     = ($urandom_range(0, 999) < 3);
      if (gap == 0) begin
        code_valid = 1'b1;
        code_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 19)];
        gap = ($urandom_range(0, 19) == 0) ? (TO - 1 + int'($urandom_range(0, 2)))
                                           : int'($urandom_range(0, 2));
      end else begin
        code_valid = 1'b0;
        gap--;
      end
      @(negedge clk);
    end
    code_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; rst = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
